// File: rtl/ccg_resp_compactor.sv
// Response compactor: MISR signature, vector count and toggle mask per run.
// Optional golden-signature comparator: define CCG_RESP_GOLDEN_CMP_EN.
module ccg_resp_compactor #(
   parameter int OUT_W = 17,
   parameter int SIG_W = 32,
   parameter int CNT_W = 16,
   parameter logic [SIG_W-1:0] POLY = 'h04C11DB7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic [SIG_W-1:0] seed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OUT_W-1:0] f,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count,
`ifdef CCG_RESP_GOLDEN_CMP_EN
   input  logic [SIG_W-1:0] golden_sig,
   output logic             pass,
   output logic             fail,
`endif
   output logic [OUT_W-1:0] toggle_mask
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [OUT_W-1:0] prev;
   logic             first;
   logic [CNT_W-1:0] num_lat;

   logic             acc;
   logic             last;
   logic [SIG_W-1:0] sig_next;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      acc      = in_valid & in_ready;
      sig_next = (signature << 1)
               ^ (signature[SIG_W-1] ? POLY : '0)
               ^ SIG_W'(f);
      cnt_next = vec_count + 1'b1;
      last     = (cnt_next == num_lat);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         signature   <= '0;
         vec_count   <= '0;
         toggle_mask <= '0;
         prev        <= '0;
         first       <= 1'b1;
         num_lat     <= '0;
`ifdef CCG_RESP_GOLDEN_CMP_EN
         pass        <= 1'b0;
         fail        <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  signature   <= seed;
                  vec_count   <= '0;
                  toggle_mask <= '0;
                  first       <= 1'b1;
                  num_lat     <= num_vectors;
`ifdef CCG_RESP_GOLDEN_CMP_EN
                  pass        <= 1'b0;
                  fail        <= 1'b0;
`endif
                  if (num_vectors == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
`ifdef CCG_RESP_GOLDEN_CMP_EN
                     pass  <= (seed == golden_sig);
                     fail  <= (seed != golden_sig);
`endif
                  end else begin
                     state    <= RUN;
                     done     <= 1'b0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (acc) begin
                  signature <= sig_next;
                  vec_count <= cnt_next;
                  prev      <= f;
                  first     <= 1'b0;
                  if (!first)
                     toggle_mask <= toggle_mask | (f ^ prev);
                  if (last) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
`ifdef CCG_RESP_GOLDEN_CMP_EN
                     pass     <= (sig_next == golden_sig);
                     fail     <= (sig_next != golden_sig);
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
